// File: rtl/i_ap_err_recover.sv
// Error detection and recovery stage for a segmented approximate adder.
// Checks the speculative sum, repairs the upper byte when needed and tracks error statistics.
module i_ap_err_recover #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      A,
    input  logic [15:0]      B,
    input  logic [15:0]      SUM_AP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      SUM,
    output logic             COUT,
    output logic             ERR,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [1:0] {IDLE, CHECK, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       a_q, a_d;
    logic [15:0]       b_q, b_d;
    logic [15:0]       ap_q, ap_d;
    logic [15:0]       sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;

    logic [16:0]       exact;
    logic              c8;
    logic              c8s;
    logic              mism;
    logic [7:0]        hi_fix;

    assign exact  = {1'b0, a_q} + {1'b0, b_q};
    // Carry into bit 8 recovered from the full sum: sum bit = a ^ b ^ carry-in.
    assign c8     = exact[8] ^ a_q[8] ^ b_q[8];
    assign c8s    = ({1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'b0, a_q[0]}) > 5'd15;
    assign mism   = (ap_q != exact[15:0]);
    assign hi_fix = ap_q[15:8] - {7'b0, c8s} + {7'b0, c8};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ap_d      = ap_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        txn_cnt_d = txn_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    ap_d    = SUM_AP;
                    state_d = CHECK;
                    if (txn_cnt_q != {CNT_W{1'b1}}) begin
                        txn_cnt_d = txn_cnt_q + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                err_d = mism;
                if (mism) begin
                    state_d = FIX;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end else begin
                    sum_d   = ap_q;
                    cout_d  = exact[16];
                    state_d = DONE;
                end
            end
            FIX: begin
                sum_d   = {hi_fix, exact[7:0]};
                cout_d  = exact[16];
                err_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ap_q      <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            txn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ap_q      <= ap_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign SUM       = sum_q;
    assign COUT      = cout_q;
    assign ERR       = err_q;
    assign err_cnt   = err_cnt_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_i_ap_err_recover.sv
// Scoreboard bench for i_ap_err_recover with a second 2-bit-counter instance
// sharing the same stimulus to exercise counter saturation.
module tb_i_ap_err_recover;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] A, B, SUM_AP;

    logic        in_ready, out_valid, COUT, ERR;
    logic [15:0] SUM;
    logic [15:0] err_cnt, txn_cnt;

    logic        s_in_ready, s_out_valid, s_cout, s_err;
    logic [15:0] s_sum;
    logic [1:0]  s_err_cnt, s_txn_cnt;

    i_ap_err_recover u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .SUM_AP(SUM_AP), .out_valid(out_valid),
        .out_ready(out_ready), .SUM(SUM), .COUT(COUT), .ERR(ERR),
        .err_cnt(err_cnt), .txn_cnt(txn_cnt)
    );

    i_ap_err_recover #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .A(A), .B(B), .SUM_AP(SUM_AP), .out_valid(s_out_valid),
        .out_ready(out_ready), .SUM(s_sum), .COUT(s_cout), .ERR(s_err),
        .err_cnt(s_err_cnt), .txn_cnt(s_txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_txn = 0;
    int   exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Segmented approximate adder: exact low byte, upper byte with a
    // carry speculated from bits [7:4] plus A[0].
    function automatic logic [15:0] approx(input logic [15:0] a,
                                           input logic [15:0] b);
        logic [7:0] lo, hi;
        logic [4:0] sp;
        lo = a[7:0] + b[7:0];
        sp = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, a[0]};
        hi = a[15:8] + b[15:8] + {7'b0, sp[4]};
        return {hi, lo};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_txn = 0;
        exp_err = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_err", ERR, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_txn_cnt", txn_cnt, 0);
        chk("rst_sat_txn", s_txn_cnt, 0);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ap);
        logic [16:0] e;
        exp_t        x;
        e = {1'b0, a} + {1'b0, b};
        x.sum  = e[15:0];
        x.cout = e[16];
        x.err  = (ap != e[15:0]);
        chk("accept_ready", in_ready, 1);
        A = a; B = b; SUM_AP = ap;
        in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(x);
        exp_txn++;
        if (x.err) exp_err++;
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom); SUM_AP = 16'($urandom);
    endtask

    task automatic collect(input bit stall);
        int   n;
        exp_t x;
        logic [15:0] s0;
        logic c0, e0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        x = sb.pop_front();
        chk("latency", n, x.err ? 3 : 2);
        chk("sum", SUM, x.sum);
        chk("cout", COUT, x.cout);
        chk("err", ERR, x.err);
        chk("err_cnt", err_cnt, sat(exp_err, 65535));
        chk("txn_cnt", txn_cnt, sat(exp_txn, 65535));
        chk("sat_err_cnt", s_err_cnt, sat(exp_err, 3));
        chk("sat_txn_cnt", s_txn_cnt, sat(exp_txn, 3));
        if (stall) begin
            s0 = SUM; c0 = COUT; e0 = ERR;
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                A = 16'($urandom); B = 16'($urandom);
                @(posedge clk); #1;
                chk("stall_valid", out_valid, 1);
                chk("stall_ready", in_ready, 0);
                chk("stall_sum", SUM, s0);
                chk("stall_cout", COUT, c0);
                chk("stall_err", ERR, e0);
                chk("stall_txn", txn_cnt, sat(exp_txn, 65535));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_txn", txn_cnt, sat(exp_txn, 65535));
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; SUM_AP = '0;
        @(posedge clk); #1;
        do_reset();

        send(16'h0088, 16'h0078, 16'h0000);
        collect(0);
        send(16'h0071, 16'h008E, 16'h01FF);
        collect(0);
        send(16'hFFFF, 16'h0001, 16'h0000);
        collect(0);
        chk("wrap_cout", COUT, 1);
        chk("wrap_err_cnt", err_cnt, 2);

        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, (i % 3 == 0) ? ra + rb : approx(ra, rb));
            collect(0);
        end

        send(16'h1248, 16'h34B8, approx(16'h1248, 16'h34B8));
        collect(1);

        send(16'h5573, 16'h118C, approx(16'h5573, 16'h118C));
        @(posedge clk); #1;
        chk("in_fix_no_valid", out_valid, 0);
        do_reset();

        send(16'h0088, 16'h0078, approx(16'h0088, 16'h0078));
        collect(0);
        send(16'h0071, 16'h008E, approx(16'h0071, 16'h008E));
        collect(0);
        send(16'h1248, 16'h34B8, approx(16'h1248, 16'h34B8));
        collect(0);
        send(16'h5573, 16'h118C, approx(16'h5573, 16'h118C));
        collect(0);
        chk("sat_err_final", s_err_cnt, 3);
        chk("sat_txn_final", s_txn_cnt, 3);
        chk("full_err_final", err_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
